// File: rtl/parking_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parking_pkg : shared sizing constants and ledger FSM state encoding         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package parking_pkg;
    localparam int NUM_SLOTS   = 8;
    localparam int SLOT_W      = 3;
    localparam int TIME_W      = 16;
    localparam int FEE_W       = 16;
    localparam int RATE        = 10;
    localparam int MS_PER_SEC  = 1000;
    localparam int SEC_PER_MIN = 60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } ledger_state_e;
endpackage
`default_nettype wire

// File: rtl/parking_ledger_sec_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sec_timer : ms-clock prescaler driving a free-running seconds counter      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sec_timer #(
    parameter int MS_PER_SEC = 1000,
    parameter int TIME_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              sec_tick_o,
    output logic [TIME_W-1:0] now_sec_o
);
    localparam int               PRE_W   = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_PER_SEC - 1);

    logic [PRE_W-1:0]  pre_q;
    logic [TIME_W-1:0] sec_q;

    assign sec_tick_o = (pre_q == PRE_MAX);
    assign now_sec_o  = sec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            sec_q <= '0;
        end else if (sec_tick_o) begin
            pre_q <= '0;
            sec_q <= sec_q + TIME_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/parking_ledger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parking_ledger : slot allocation on entry, duration-based fee on exit      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module parking_ledger
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS  = parking_pkg::NUM_SLOTS,
    parameter int SLOT_W     = parking_pkg::SLOT_W,
    parameter int TIME_W     = parking_pkg::TIME_W,
    parameter int MS_PER_SEC = parking_pkg::MS_PER_SEC,
    parameter int RATE       = parking_pkg::RATE,
    parameter int FEE_W      = parking_pkg::FEE_W
) (
    input  logic                 ms,
    input  logic                 rst,
    input  logic                 activateSave,
    input  logic                 isOut,
    input  logic [SLOT_W-1:0]    slot_sel,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [SLOT_W:0]      free_count,
    output logic                 full,
    output logic                 busy,
    output logic [SLOT_W-1:0]    ticket_slot,
    output logic                 ticket_valid,
    output logic [FEE_W-1:0]     fee,
    output logic                 fee_valid,
    output logic                 err,
    output logic [TIME_W-1:0]    now_sec
);
    localparam int                PAD_W   = 2 ** SLOT_W;
    localparam int                PROD_W  = TIME_W + 32;
    localparam logic [TIME_W-1:0] MIN_LEN = TIME_W'(SEC_PER_MIN);
    localparam logic [PROD_W-1:0] FEE_MAX = PROD_W'({FEE_W{1'b1}});

    ledger_state_e        state_q, state_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [TIME_W-1:0]    dur_q, dur_d;
    logic [TIME_W-1:0]    min_q, min_d;
    logic [SLOT_W-1:0]    tslot_q, tslot_d;
    logic [FEE_W-1:0]     fee_q, fee_d;
    logic                 tvalid_q, tvalid_d;
    logic                 fvalid_q, fvalid_d;
    logic                 err_q, err_d;
    logic [TIME_W-1:0]    entry_q [NUM_SLOTS];

    logic                 w_sec_tick_unused;
    logic [PAD_W-1:0]     w_occ_pad;
    logic [SLOT_W-1:0]    w_free_slot;
    logic [SLOT_W:0]      w_free_cnt;
    logic [PROD_W-1:0]    w_prod;
    logic [FEE_W-1:0]     w_fee_sat;

    sec_timer #(
        .MS_PER_SEC (MS_PER_SEC),
        .TIME_W     (TIME_W)
    ) u_sec_timer (
        .clk        (ms),
        .rst        (rst),
        .sec_tick_o (w_sec_tick_unused),
        .now_sec_o  (now_sec)
    );

    // Padding to a power of two makes out-of-range slot_sel read as empty.
    assign w_occ_pad = PAD_W'(occ_q);

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        w_free_cnt  = '0;
        w_free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                w_free_cnt  = w_free_cnt + (SLOT_W + 1)'(1);
                w_free_slot = SLOT_W'(i);
            end
        end
    end

    assign w_prod    = PROD_W'(min_q) * PROD_W'(RATE);
    assign w_fee_sat = (w_prod > FEE_MAX) ? {FEE_W{1'b1}} : w_prod[FEE_W-1:0];

    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q;
        slot_d   = slot_q;
        dur_d    = dur_q;
        min_d    = min_q;
        tslot_d  = tslot_q;
        fee_d    = fee_q;
        tvalid_d = 1'b0;
        fvalid_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (activateSave) begin
                    if (!isOut) begin
                        if (full) err_d   = 1'b1;
                        else      state_d = ST_ALLOC;
                    end else if (w_occ_pad[slot_sel]) begin
                        slot_d  = slot_sel;
                        dur_d   = now_sec - entry_q[slot_sel];
                        min_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ALLOC: begin
                occ_d[w_free_slot] = 1'b1;
                tslot_d            = w_free_slot;
                tvalid_d           = 1'b1;
                state_d            = ST_IDLE;
            end
            ST_CALC: begin
                // The final step also counts the started (or empty) minute.
                min_d = min_q + TIME_W'(1);
                if (dur_q >= MIN_LEN) dur_d   = dur_q - MIN_LEN;
                else                  state_d = ST_DONE;
            end
            ST_DONE: begin
                fee_d         = w_fee_sat;
                fvalid_d      = 1'b1;
                occ_d[slot_q] = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (activateSave && (state_q != ST_IDLE)) err_d = 1'b1;
    end

    always_ff @(posedge ms or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            occ_q    <= '0;
            slot_q   <= '0;
            dur_q    <= '0;
            min_q    <= '0;
            tslot_q  <= '0;
            fee_q    <= '0;
            tvalid_q <= 1'b0;
            fvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            slot_q   <= slot_d;
            dur_q    <= dur_d;
            min_q    <= min_d;
            tslot_q  <= tslot_d;
            fee_q    <= fee_d;
            tvalid_q <= tvalid_d;
            fvalid_q <= fvalid_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge ms) begin
        if (state_q == ST_ALLOC) entry_q[w_free_slot] <= now_sec;
    end

    assign occupied     = occ_q;
    assign free_count   = w_free_cnt;
    assign full         = (w_free_cnt == '0);
    assign busy         = (state_q != ST_IDLE);
    assign ticket_slot  = tslot_q;
    assign ticket_valid = tvalid_q;
    assign fee          = fee_q;
    assign fee_valid    = fvalid_q;
    assign err          = err_q;
endmodule
`default_nettype wire

// File: tb/tb_parking_ledger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parking_ledger : two ledger configurations against a behavioural model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_parking_ledger;
    logic ms = 1'b0;
    logic rst = 1'b1;
    logic       i_act [2];
    logic       i_out [2];
    logic [2:0] i_sel [2];

    logic [7:0] a_occ;  logic [3:0] a_free; logic a_full, a_busy, a_tv, a_fv, a_err;
    logic [2:0] a_tslot; logic [15:0] a_fee; logic [15:0] a_now;
    logic [5:0] b_occ;  logic [3:0] b_free; logic b_full, b_busy, b_tv, b_fv, b_err;
    logic [2:0] b_tslot; logic [15:0] b_fee; logic [7:0] b_now;

    logic [7:0]  o_occ [2];  logic [3:0]  o_free [2]; logic o_full [2]; logic o_busy [2];
    logic        o_tv [2];   logic        o_fv [2];   logic o_err [2];
    logic [2:0]  o_tslot [2]; logic [15:0] o_fee [2]; logic [15:0] o_now [2];

    parking_ledger #(.NUM_SLOTS(8), .SLOT_W(3), .TIME_W(16), .MS_PER_SEC(10), .RATE(10), .FEE_W(16)) u_dut_a (
        .ms(ms), .rst(rst), .activateSave(i_act[0]), .isOut(i_out[0]), .slot_sel(i_sel[0]),
        .occupied(a_occ), .free_count(a_free), .full(a_full), .busy(a_busy),
        .ticket_slot(a_tslot), .ticket_valid(a_tv), .fee(a_fee), .fee_valid(a_fv),
        .err(a_err), .now_sec(a_now));

    parking_ledger #(.NUM_SLOTS(6), .SLOT_W(3), .TIME_W(8), .MS_PER_SEC(2), .RATE(40000), .FEE_W(16)) u_dut_b (
        .ms(ms), .rst(rst), .activateSave(i_act[1]), .isOut(i_out[1]), .slot_sel(i_sel[1]),
        .occupied(b_occ), .free_count(b_free), .full(b_full), .busy(b_busy),
        .ticket_slot(b_tslot), .ticket_valid(b_tv), .fee(b_fee), .fee_valid(b_fv),
        .err(b_err), .now_sec(b_now));

    assign o_occ[0] = a_occ;   assign o_occ[1] = {2'b00, b_occ};
    assign o_free[0] = a_free; assign o_free[1] = b_free;
    assign o_full[0] = a_full; assign o_full[1] = b_full;
    assign o_busy[0] = a_busy; assign o_busy[1] = b_busy;
    assign o_tv[0] = a_tv;     assign o_tv[1] = b_tv;
    assign o_fv[0] = a_fv;     assign o_fv[1] = b_fv;
    assign o_err[0] = a_err;   assign o_err[1] = b_err;
    assign o_tslot[0] = a_tslot; assign o_tslot[1] = b_tslot;
    assign o_fee[0] = a_fee;   assign o_fee[1] = b_fee;
    assign o_now[0] = a_now;   assign o_now[1] = {8'h00, b_now};

    always #5 ms = ~ms;

    int unsigned cyc;
    always @(posedge ms or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Reference model: configuration, occupancy, entry times, last results.
    int ms_p [2] = '{10, 2};
    int tw_p [2] = '{16, 8};
    int ns_p [2] = '{8, 6};
    longint rate_p [2] = '{10, 40000};
    bit occ_m [2][8];
    int ent_m [2][8];
    int last_fee [2];
    int last_ts [2];

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int now_m(input int d, input int unsigned c);
        return int'((c / ms_p[d]) % (1 << tw_p[d]));
    endfunction

    function automatic int nfree_m(input int d);
        int n = 0;
        for (int i = 0; i < ns_p[d]; i++) if (!occ_m[d][i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) occ_m[d][i] = 1'b0;
            last_fee[d] = 0;
            last_ts[d]  = 0;
        end
    endtask

    task automatic check_state(input int d, input string tag);
        logic [7:0] eocc = '0;
        int nf = nfree_m(d);
        for (int i = 0; i < ns_p[d]; i++) eocc[i] = occ_m[d][i];
        chk({tag, "/occupied"}, o_occ[d], eocc);
        chk({tag, "/free_count"}, o_free[d], nf);
        chk({tag, "/full"}, o_full[d], nf == 0);
        chk({tag, "/busy"}, o_busy[d], 0);
        chk({tag, "/now_sec"}, o_now[d], now_m(d, cyc));
        chk({tag, "/fee"}, o_fee[d], last_fee[d]);
        chk({tag, "/ticket_slot"}, o_tslot[d], last_ts[d]);
    endtask

    // One strobe on DUT d; called and returns at a falling edge.
    task automatic txn(input int d, input bit out, input int slot, input bit poke, input string tag);
        int unsigned c0 = cyc;
        bit ok = 1'b0;
        int s = 0, dur = 0, m = 1 << tw_p[d];
        longint fexp = 0;
        int lat = 0, span, tv_n = 0, tv_c = 0, fv_n = 0, fv_c = 0, er_n = 0, er_c = 0, tv_val = 0;
        if (!out) begin
            ok = nfree_m(d) > 0;
            for (int i = ns_p[d] - 1; i >= 0; i--) if (!occ_m[d][i]) s = i;
            lat = 2;
        end else begin
            ok = (slot < ns_p[d]) && occ_m[d][slot];
            if (ok) begin
                dur  = ((now_m(d, c0) - ent_m[d][slot]) % m + m) % m;
                fexp = longint'(dur / 60 + 1) * rate_p[d];
                if (fexp > 65535) fexp = 65535;
                lat  = dur / 60 + 3;
            end
        end
        poke = poke && ok;
        span = ok ? lat + 1 : 2;
        i_act[d] = 1'b1; i_out[d] = out; i_sel[d] = 3'(slot);
        for (int n = 1; n <= span; n++) begin
            @(posedge ms); @(negedge ms);
            i_act[d] = (n == 1) ? poke : 1'b0;
            if (o_tv[d])  begin tv_c++; if (tv_n == 0) begin tv_n = n; tv_val = int'(o_tslot[d]); end end
            if (o_fv[d])  begin fv_c++; if (fv_n == 0) fv_n = n; end
            if (o_err[d]) begin er_c++; if (er_n == 0) er_n = n; end
        end
        chk({tag, "/ticket_latency"}, tv_n, (ok && !out) ? 2 : 0);
        chk({tag, "/ticket_pulses"}, tv_c, (ok && !out) ? 1 : 0);
        chk({tag, "/fee_latency"}, fv_n, (ok && out) ? lat : 0);
        chk({tag, "/fee_pulses"}, fv_c, (ok && out) ? 1 : 0);
        chk({tag, "/err_cycle"}, er_n, !ok ? 1 : (poke ? 2 : 0));
        chk({tag, "/err_pulses"}, er_c, (!ok || poke) ? 1 : 0);
        if (ok && !out) begin
            chk({tag, "/ticket_value"}, tv_val, s);
            occ_m[d][s] = 1'b1;
            ent_m[d][s] = now_m(d, c0 + 1);
            last_ts[d]  = s;
        end
        if (ok && out) begin
            occ_m[d][slot] = 1'b0;
            last_fee[d]    = int'(fexp);
        end
        check_state(d, tag);
    endtask

    task automatic wait_to_now(input int d, input int target);
        int g = 0;
        while (now_m(d, cyc) != target % (1 << tw_p[d]) && g < 20000) begin
            @(negedge ms);
            g++;
        end
        chk("wait_timeout", g >= 20000, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int s, occ_slot, fv_seen;
        for (int d = 0; d < 2; d++) begin i_act[d] = 1'b0; i_out[d] = 1'b0; i_sel[d] = 3'd0; end
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge ms);
        rst = 1'b0;
        check_state(0, "reset_a");
        check_state(1, "reset_b");
        chk("reset_a/pulses", {a_tv, a_fv, a_err}, 3'b000);

        // Three entries, then a 125 s stay, a zero-length stay and a 60 s stay.
        for (int k = 0; k < 3; k++) begin
            repeat (20) @(negedge ms);
            txn(0, 1'b0, 0, 1'b0, "entry3");
        end
        wait_to_now(0, ent_m[0][0] + 125);
        txn(0, 1'b1, 0, 1'b0, "exit125");
        while (cyc % 10 != 0) @(negedge ms);
        txn(0, 1'b0, 0, 1'b0, "entry_same");
        txn(0, 1'b1, 0, 1'b0, "exit_same");
        txn(0, 1'b0, 0, 1'b0, "entry_60");
        wait_to_now(0, ent_m[0][0] + 60);
        txn(0, 1'b1, 0, 1'b0, "exit_60");

        // Randomised traffic, occasionally strobing again while busy.
        for (int k = 0; k < 30; k++) begin
            bit out = 1'($urandom % 2);
            int sl = int'($urandom % 8);
            if (out && ($urandom % 3 != 0))
                for (int i = 0; i < 8; i++) if (occ_m[0][i] && ($urandom % 2 == 0)) sl = i;
            repeat ($urandom_range(0, 150)) @(negedge ms);
            txn(0, out, sl, 1'($urandom % 4 == 0), "random");
        end

        // Fill, overflow, and double release.
        while (nfree_m(0) > 0) txn(0, 1'b0, 0, 1'b0, "fill");
        txn(0, 1'b0, 0, 1'b0, "entry_full");
        txn(0, 1'b1, 3, 1'b0, "exit_slot3");
        txn(0, 1'b1, 3, 1'b0, "exit_empty");

        // Narrow timestamp wrap, fee saturation and out-of-range slots.
        wait_to_now(1, 250);
        txn(1, 1'b0, 0, 1'b0, "b_entry250");
        wait_to_now(1, 10);
        txn(1, 1'b1, 0, 1'b0, "b_exit_wrap");
        txn(1, 1'b0, 0, 1'b0, "b_entry_sat");
        wait_to_now(1, ent_m[1][0] + 70);
        txn(1, 1'b1, 0, 1'b0, "b_exit_sat");
        txn(1, 1'b1, 6, 1'b0, "b_slot6");
        txn(1, 1'b1, 7, 1'b0, "b_slot7");
        while (nfree_m(1) > 0) txn(1, 1'b0, 0, 1'b0, "b_fill");
        txn(1, 1'b0, 0, 1'b0, "b_entry_full");

        // Reset in the middle of a long exit calculation.
        occ_slot = 0;
        for (int i = 7; i >= 0; i--) if (occ_m[0][i]) occ_slot = i;
        wait_to_now(0, ent_m[0][occ_slot] + 300);
        i_act[0] = 1'b1; i_out[0] = 1'b1; i_sel[0] = 3'(occ_slot);
        @(posedge ms); @(negedge ms);
        i_act[0] = 1'b0;
        repeat (2) @(posedge ms);
        @(negedge ms);
        chk("midcalc/busy", a_busy, 1);
        @(posedge ms);
        #2 rst = 1'b1;
        #1;
        chk("rst_async/occupied", a_occ, 0);
        chk("rst_async/free_count", a_free, 8);
        chk("rst_async/flags", {a_full, a_busy, a_tv, a_fv, a_err}, 5'b00000);
        chk("rst_async/ticket_slot", a_tslot, 0);
        chk("rst_async/fee", a_fee, 0);
        chk("rst_async/now_sec", a_now, 0);
        chk("rst_async/b_occupied", b_occ, 0);
        model_reset();
        @(negedge ms);
        rst = 1'b0;
        fv_seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge ms);
            if (a_fv) fv_seen++;
        end
        chk("post_rst/no_fee_valid", fv_seen, 0);
        txn(0, 1'b0, 0, 1'b0, "post_rst_entry");
        s = last_ts[0];
        chk("post_rst/slot0", s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
